// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller.
// FSM states and the stall/flush source codes, highest priority first.
package pipe_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_MULT
  } haz_state_e;

  typedef enum logic [2:0] {
    SRC_DMEM,
    SRC_MULT,
    SRC_LDUSE,
    SRC_MSTART,
    SRC_REDIR,
    SRC_IMEM,
    SRC_NONE
  } haz_src_e;

endpackage

// File: rtl/pipe_hazard_ctl_mult_hold_cnt.sv
// Multiply/divide hold down-counter for the hazard controller.
// Loads on start, counts while active and not frozen, pulses done at zero.
module mult_hold_cnt #(
  parameter  int MULT_CYCLES = 32,
  localparam int CNT_W = $clog2(MULT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  input  logic freeze,
  output logic done
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(MULT_CYCLES - 1);

  logic [CNT_W-1:0] mcnt;

  // remaining hold cycles; holds whenever the pipe is frozen
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcnt <= '0;
    end else if (start) begin
      mcnt <= LOAD;
    end else if (active && !freeze && mcnt != '0) begin
      mcnt <= mcnt - 1'b1;
    end
  end

  // last hold cycle, only when the pipe actually moves
  always_comb begin
    done = rst && active && !freeze && (mcnt == '0);
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Stall/flush arbiter for the 5-stage pipeline.
// Optional perf counters under HAZ_PERF_EN.
module pipe_hazard_ctl
  import pipe_pkg::*;
#(
  parameter  int REG_AW = 5,
  parameter  int MULT_CYCLES = 32,
  localparam int CNT_W = $clog2(MULT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              id_is_mult,
  input  logic              id_redirect,
  input  logic              imem_ready,
  input  logic              mem_access,
  input  logic              dmem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              pipe_en,
  output logic              mult_busy,
  output logic              mult_done,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
);

  haz_state_e state_q;
  haz_state_e state_d;
  haz_src_e   src;
  logic       frozen;
  logic       ld_use;
  logic       served;

  assign frozen = mem_access & ~dmem_ready;

  assign ld_use = ex_memread && (ex_rt != '0) &&
                  ((id_uses_rs && id_rs == ex_rt) ||
                   (id_uses_rt && id_rt == ex_rt));

  // highest-priority active stall/flush source
  always_comb begin
    src = SRC_NONE;
    if (frozen)                          src = SRC_DMEM;
    else if (state_q == ST_MULT)         src = SRC_MULT;
    else if (ld_use)                     src = SRC_LDUSE;
    else if (id_is_mult && !served)      src = SRC_MSTART;
    else if (id_redirect)                src = SRC_REDIR;
    else if (!imem_ready)                src = SRC_IMEM;
  end

  mult_hold_cnt #(
    .MULT_CYCLES(MULT_CYCLES)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .start (src == SRC_MSTART),
    .active(state_q == ST_MULT),
    .freeze(frozen),
    .done  (mult_done)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (src == SRC_MSTART) state_d = ST_MULT;
      ST_MULT: if (mult_done)         state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // a finished mult stays in ID one more cycle; keep it from restarting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          served <= 1'b0;
    else if (mult_done) served <= 1'b1;
    else if (if_id_en)  served <= 1'b0;
  end

  // pipeline control outputs
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_en     = 1'b1;
    mult_busy   = rst && (state_q == ST_MULT);
    if (!rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pipe_en     = 1'b0;
    end else begin
      unique case (src)
        SRC_DMEM: begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
          pipe_en  = 1'b0;
        end
        SRC_MULT, SRC_LDUSE, SRC_MSTART: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
        SRC_REDIR: if_id_flush = 1'b1;
        SRC_IMEM: begin
          pc_en       = 1'b0;
          if_id_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef HAZ_PERF_EN
  // stall and flush cycle counters, free-running wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en) stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush || id_ex_flush) flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl: directed scenarios plus random traffic
// against a cycle-level reference model.
module tb_pipe_hazard_ctl;

  localparam int MC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, ex_memread, id_is_mult;
  logic       id_redirect, imem_ready, mem_access, dmem_ready;
  logic       pc_en, if_id_en, if_id_flush, id_ex_flush, pipe_en;
  logic       mult_busy, mult_done;
  logic [31:0] stall_cycles, flush_count;

  int n_chk = 0;
  int n_err = 0;

  // model state: remaining MULT cycles, served flag, perf counts
  int          hold = 0;
  bit          served = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  int c_pc0, c_busy, c_done, c_pipe0;

  pipe_hazard_ctl #(.REG_AW(5), .MULT_CYCLES(MC)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt),
    .id_is_mult(id_is_mult), .id_redirect(id_redirect),
    .imem_ready(imem_ready), .mem_access(mem_access),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .pipe_en(pipe_en), .mult_busy(mult_busy), .mult_done(mult_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; ex_memread = 0;
    id_is_mult = 0; id_redirect = 0;
    imem_ready = 1; mem_access = 0; dmem_ready = 1;
  endtask

  task automatic clr_counts();
    c_pc0 = 0; c_busy = 0; c_done = 0; c_pipe0 = 0;
  endtask

  // one clock: check at negedge against the model, advance at posedge
  task automatic step();
    bit frz, lu, start, e_busy, e_done;
    bit e_pc, e_ifid, e_iff, e_idf, e_pipe;
    @(negedge clk);
    frz = mem_access && !dmem_ready;
    lu  = ex_memread && ex_rt != 0 &&
          ((id_uses_rs && id_rs == ex_rt) ||
           (id_uses_rt && id_rt == ex_rt));
    start  = 0;
    e_busy = rst && hold > 0;
    e_done = rst && hold == 1 && !frz;
    {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b11001;
    if (!rst)                      {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b00110;
    else if (frz)                  {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b00000;
    else if (hold > 0)             {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b00011;
    else if (lu)                   {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b00011;
    else if (id_is_mult && !served) begin
      {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b00011;
      start = 1;
    end
    else if (id_redirect)          {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b11101;
    else if (!imem_ready)          {e_pc, e_ifid, e_iff, e_idf, e_pipe} = 5'b01101;
    chk("pc_en", pc_en, e_pc);
    chk("if_id_en", if_id_en, e_ifid);
    chk("if_id_flush", if_id_flush, e_iff);
    chk("id_ex_flush", id_ex_flush, e_idf);
    chk("pipe_en", pipe_en, e_pipe);
    chk("mult_busy", mult_busy, e_busy);
    chk("mult_done", mult_done, e_done);
`ifdef HAZ_PERF_EN
    chk("stall_cycles", stall_cycles, rst ? m_stall : 0);
    chk("flush_count", flush_count, rst ? m_flush : 0);
`else
    chk("stall_cycles", stall_cycles, 0);
    chk("flush_count", flush_count, 0);
`endif
    if (!pc_en) c_pc0++;
    if (mult_busy) c_busy++;
    if (mult_done) c_done++;
    if (!pipe_en) c_pipe0++;
    @(posedge clk);
    if (!rst) begin
      hold = 0; served = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!e_pc) m_stall++;
      if (e_iff || e_idf) m_flush++;
      if (e_done) served = 1;
      else if (e_ifid) served = 0;
      if (!frz && hold > 0) hold--;
      if (start) hold = MC;
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 0;
    #1;
    step();
    step();
    rst = 1;

    // first cycle after release
    step();

    // load-use on r8, then against r0
    ex_memread = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1;
    clr_counts();
    step();
    idle();
    step();
    chk("ldu_stall_cnt", c_pc0, 1);
    ex_memread = 1; ex_rt = 0; id_rs = 0; id_uses_rs = 1;
    clr_counts();
    step();
    idle();
    chk("ldu_r0_cnt", c_pc0, 0);

    // plain multiply
    clr_counts();
    id_is_mult = 1;
    step();
    id_is_mult = 0;
    repeat (6) step();
    chk("mult_pc0", c_pc0, 5);
    chk("mult_busy_n", c_busy, 4);
    chk("mult_done_n", c_done, 1);

    // multiply with a 3-cycle dmem freeze inside
    clr_counts();
    id_is_mult = 1;
    step();
    id_is_mult = 0;
    step();
    mem_access = 1; dmem_ready = 0;
    repeat (3) step();
    idle();
    repeat (6) step();
    chk("mfrz_pc0", c_pc0, 8);
    chk("mfrz_pipe0", c_pipe0, 3);
    chk("mfrz_done_n", c_done, 1);

    // redirect beats imem stall, loses to load-use
    id_redirect = 1; imem_ready = 0;
    step();
    ex_memread = 1; ex_rt = 8; id_rs = 8; id_uses_rs = 1;
    clr_counts();
    step();
    chk("redir_ldu_pc0", c_pc0, 1);
    idle();
    step();

    // reset in the middle of a multiply
    id_is_mult = 1;
    step();
    id_is_mult = 0;
    step();
    rst = 0;
    clr_counts();
    step();
    chk("rst_busy", c_busy, 0);
    rst = 1;
    clr_counts();
    repeat (6) step();
    chk("rst_no_done", c_done, 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(0, 149) != 0);
      id_rs       = 5'($urandom_range(0, 3));
      id_rt       = 5'($urandom_range(0, 3));
      ex_rt       = 5'($urandom_range(0, 3));
      id_uses_rs  = 1'($urandom_range(0, 1));
      id_uses_rt  = 1'($urandom_range(0, 1));
      ex_memread  = ($urandom_range(0, 3) == 0);
      id_is_mult  = ($urandom_range(0, 5) == 0);
      id_redirect = ($urandom_range(0, 5) == 0);
      imem_ready  = ($urandom_range(0, 4) != 0);
      mem_access  = ($urandom_range(0, 2) == 0);
      dmem_ready  = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1;
    idle();
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
